// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin ties, bounded port locking and 1-cycle read return.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie in IDLE.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned LOCK_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_lock,
  input  logic [3:0]  p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_lock,
  input  logic [3:0]  p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] rdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned    CW       = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]  LOCK_LIM = CW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_next;
  logic          last_gnt, last_gnt_next;   // 1: port 1 was granted most recently
  logic [CW-1:0] lock_cnt, lock_cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          gnt0, gnt1, any_gnt, lock_sel;
  logic          rv0, rv1;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_we;

  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    lock_cnt_next = lock_cnt;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    cnt_inc       = '0;
    lock_sel      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (p0_req && p1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
`endif
          end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
          end
        end
        OWN0:    gnt0 = p0_req;
        OWN1:    gnt1 = p1_req;
        default: ;
      endcase

      // The grant that takes the lock from IDLE is the first of the LOCK_MAX allowed.
      cnt_inc  = (state == IDLE) ? CW'(1) : lock_cnt + CW'(1);
      lock_sel = gnt1 ? p1_lock : p0_lock;
      if (gnt0 || gnt1) begin
        last_gnt_next = gnt1;
        if (lock_sel && (cnt_inc < LOCK_LIM)) begin
          state_next    = gnt1 ? OWN1 : OWN0;
          lock_cnt_next = cnt_inc;
        end else begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end
      end else if ((state == OWN0 && !p0_lock) || (state == OWN1 && !p1_lock)) begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    end
  end

  assign any_gnt   = gnt0 || gnt1;
  assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
  assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
  assign sel_we    = gnt1 ? p1_we    : p0_we;

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign mem_we    = any_gnt ? sel_we : 4'b0000;
  assign mem_addr  = any_gnt ? (sel_addr - BASE_ADDR) : addr_q;
  assign mem_wdata = any_gnt ? sel_wdata : wdata_q;

  // Gating with rst drops a read whose data would land in the reset cycle.
  assign p0_rvalid = rv0 && !rst;
  assign p1_rvalid = rv1 && !rst;
  assign rdata     = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
      lock_cnt <= lock_cnt_next;
      rv0      <= gnt0 && (p0_we == 4'b0000);
      rv1      <= gnt1 && (p1_we == 4'b0000);
      if (any_gnt) begin
        addr_q  <= sel_addr - BASE_ADDR;
        wdata_q <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small byte-lane synchronous memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_lock, p1_req, p1_lock;
  logic [3:0]  p0_we, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.BASE_ADDR(32'h0001_0000), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:15];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    p0_req = 1'b0; p0_lock = 1'b0; p0_we = 4'h0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_lock = 1'b0; p1_we = 4'h0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); quiet(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  bit          e0, prev_e0;
  logic [31:0] exp_addr;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[1]  = 32'hA5A5_A5A5;
    mem[4]  = 32'hDEAD_BEEF;
    mem[8]  = 32'h1111_2222;
    mem[12] = 32'h1122_3344;

    // Reset with requests pending
    quiet();
    rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1; p0_we = 4'hF; p1_we = 4'hF;
    @(negedge clk); #2;
    check("rst_p0_gnt", 32'(p0_gnt), 0);
    check("rst_p1_gnt", 32'(p1_gnt), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 0);
    @(negedge clk); quiet(); rst = 1'b0;

    // Single read, zero-latency grant, data one cycle later
    @(negedge clk); p0_req = 1'b1; p0_addr = 32'h0001_0010; #2;
    check("rd_p0_gnt", 32'(p0_gnt), 1);
    check("rd_p1_gnt", 32'(p1_gnt), 0);
    check("rd_mem_addr", mem_addr, 32'h10);
    check("rd_mem_we", 32'(mem_we), 0);
    @(negedge clk); quiet(); #2;
    check("rd_p0_rvalid", 32'(p0_rvalid), 1);
    check("rd_p1_rvalid", 32'(p1_rvalid), 0);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_nogrant_gnt", 32'(p0_gnt), 0);
    check("rd_hold_addr", mem_addr, 32'h10);

    // Address below BASE_ADDR wraps modulo 2^32
    @(negedge clk); p0_req = 1'b1; p0_addr = 32'h0000_0008; #2;
    check("wrap_mem_addr", mem_addr, 32'hFFFF_0008);
    @(negedge clk); quiet(); #2;
    check("wrap_rdata", rdata, 32'h1000_0002);

    // Contention straight after reset
    do_reset();
    prev_e0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p0_req = 1'b1; p0_addr = 32'h0001_0004;
      p1_req = 1'b1; p1_addr = 32'h0001_0020;
      #2;
      e0 = FIXED || (k % 2 == 0);
      exp_addr = e0 ? 32'h04 : 32'h20;
      check($sformatf("tie%0d_p0_gnt", k), 32'(p0_gnt), 32'(e0));
      check($sformatf("tie%0d_p1_gnt", k), 32'(p1_gnt), 32'(!e0));
      check($sformatf("tie%0d_mem_addr", k), mem_addr, exp_addr);
      if (k > 0) begin
        check($sformatf("tie%0d_p0_rvalid", k), 32'(p0_rvalid), 32'(prev_e0));
        check($sformatf("tie%0d_rdata", k), rdata, prev_e0 ? 32'hA5A5_A5A5 : 32'h1111_2222);
      end
      prev_e0 = e0;
    end
    @(negedge clk); quiet(); #2;
    check("tie_last_p0_rvalid", 32'(p0_rvalid), 32'(FIXED));
    check("tie_last_p1_rvalid", 32'(p1_rvalid), 32'(!FIXED));

    // Locked byte-lane write from p1 while p0 waits
    @(negedge clk);
    p1_req = 1'b1; p1_lock = 1'b1; p1_we = 4'b0100; p1_addr = 32'h0001_0030; p1_wdata = 32'h00AB_0000;
    #2;
    check("lk_c0_p1_gnt", 32'(p1_gnt), 1);
    check("lk_c0_mem_we", 32'(mem_we), 32'b0100);
    check("lk_c0_mem_addr", mem_addr, 32'h30);
    check("lk_c0_mem_wdata", mem_wdata, 32'h00AB_0000);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); p0_req = 1'b1; p0_addr = 32'h0001_0004; #2;
      check($sformatf("lk_c%0d_p1_gnt", k), 32'(p1_gnt), 1);
      check($sformatf("lk_c%0d_p0_gnt", k), 32'(p0_gnt), 0);
      check($sformatf("lk_c%0d_p1_rvalid", k), 32'(p1_rvalid), 0);
    end
    @(negedge clk); p1_req = 1'b0; p1_lock = 1'b0; p1_we = 4'h0; #2;
    check("lk_c3_p0_gnt", 32'(p0_gnt), 0);
    check("lk_c3_p1_gnt", 32'(p1_gnt), 0);
    check("lk_c3_mem_we", 32'(mem_we), 0);
    @(negedge clk); #2;
    check("lk_c4_p0_gnt", 32'(p0_gnt), 1);
    @(negedge clk); p0_addr = 32'h0001_0030; #2;
    check("lk_c5_p0_rvalid", 32'(p0_rvalid), 1);
    check("lk_c5_rdata", rdata, 32'hA5A5_A5A5);
    check("lk_c5_p0_gnt", 32'(p0_gnt), 1);
    @(negedge clk); quiet(); #2;
    check("lk_wr_merge", rdata, 32'h11AB_3344);

    // Lock held past LOCK_MAX
    @(negedge clk); p1_req = 1'b1; p1_lock = 1'b1; p1_addr = 32'h0001_0020; #2;
    check("lm_g0_p1_gnt", 32'(p1_gnt), 1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); p0_req = 1'b1; p0_addr = 32'h0001_0004; #2;
      check($sformatf("lm_g%0d_p1_gnt", k), 32'(p1_gnt), 1);
      check($sformatf("lm_g%0d_p0_gnt", k), 32'(p0_gnt), 0);
      if (k == 1) check("lm_g1_p1_rvalid", 32'(p1_rvalid), 1);
    end
    @(negedge clk); #2;
    check("lm_after_p0_gnt", 32'(p0_gnt), 1);
    check("lm_after_p1_gnt", 32'(p1_gnt), 0);
    check("lm_after_p1_rvalid", 32'(p1_rvalid), 1);
    @(negedge clk); p0_req = 1'b0; #2;
    check("lm_relock_p1_gnt", 32'(p1_gnt), 1);
    check("lm_relock_p0_rvalid", 32'(p0_rvalid), 1);
    check("lm_relock_rdata", rdata, 32'hA5A5_A5A5);
    @(negedge clk); quiet(); #2;
    check("lm_release_gnt", 32'(p1_gnt), 0);
    check("lm_release_p1_rvalid", 32'(p1_rvalid), 1);

    // Reset right after a locked p0 read grant drops the read and the lock
    @(negedge clk); p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 32'h0001_0010; #2;
    check("rr_p0_gnt", 32'(p0_gnt), 1);
    @(negedge clk); rst = 1'b1; #2;
    check("rr_p0_rvalid", 32'(p0_rvalid), 0);
    check("rr_p0_gnt_in_rst", 32'(p0_gnt), 0);
    check("rr_mem_we", 32'(mem_we), 0);
    @(negedge clk); rst = 1'b0; quiet(); p1_req = 1'b1; p1_addr = 32'h0001_0020; #2;
    check("rr_after_p0_rvalid", 32'(p0_rvalid), 0);
    check("rr_idle_p1_gnt", 32'(p1_gnt), 1);
    @(negedge clk); quiet(); #2;
    check("rr_idle_p1_rvalid", 32'(p1_rvalid), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
